// File: rtl/sa_pkg.sv
// +-----------------------------------------------------------------------------
// | sa_pkg
// | Status-array widths, the per-way word layout and the shared write request.
// | Rev 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package sa_pkg;

    localparam int SET_ADDR_WIDTH = 4;
    localparam int NUM_WAYS       = 4;
    localparam int SA_WORD_WIDTH  = 2 * NUM_WAYS;

    // Way w occupies bits [2w+1:2w] = {use[w], valid[w]}.
    function automatic int use_bit_idx(input int way);
        return 2 * way + 1;
    endfunction

    function automatic int valid_bit_idx(input int way);
        return 2 * way;
    endfunction

    typedef struct packed {
        logic [SET_ADDR_WIDTH-1:0] set_addr;
        logic [SA_WORD_WIDTH-1:0]  data;
        logic [NUM_WAYS-1:0]       mask;
    } sa_w_req;

endpackage

`default_nettype wire

// File: rtl/ubit_next_calc.sv
// +-----------------------------------------------------------------------------
// | ubit_next_calc
// | NRU use-bit update for one hit: sets the hit way's use bit, and when that
// | would saturate the set, restarts with only the hit way marked.
// | Rev 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module ubit_next_calc
    import sa_pkg::*;
(
    input  logic [SA_WORD_WIDTH-1:0] i_sa_word,
    input  logic [NUM_WAYS-1:0]      i_hit_way,
    output logic [SA_WORD_WIDTH-1:0] o_data,
    output logic [NUM_WAYS-1:0]      o_mask
);

    logic [NUM_WAYS-1:0] w_u_old;
    logic [NUM_WAYS-1:0] w_u_or;
    logic [NUM_WAYS-1:0] w_u_new;

    always_comb begin
        w_u_old = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            w_u_old[w] = i_sa_word[use_bit_idx(w)];
        end
        w_u_or  = w_u_old | i_hit_way;
        w_u_new = (&w_u_or) ? i_hit_way : w_u_or;
        o_mask  = w_u_old ^ w_u_new;
        // Valid bits pass through untouched; only use bits are rewritten.
        o_data  = i_sa_word;
        for (int w = 0; w < NUM_WAYS; w++) begin
            o_data[use_bit_idx(w)] = w_u_new[w];
        end
    end

endmodule

`default_nettype wire

// File: rtl/ubit_updater.sv
// +-----------------------------------------------------------------------------
// | ubit_updater
// | Queues masked use-bit writes for hit sets and presents them to the status
// | array write arbiter. Define UBIT_COALESCE_EN to merge same-set hits into
// | queued non-head entries.
// | Rev 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module ubit_updater
    import sa_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_hit_valid,
    input  logic [SET_ADDR_WIDTH-1:0] i_hit_set_addr,
    input  logic [NUM_WAYS-1:0]       i_hit_way,
    input  logic [SA_WORD_WIDTH-1:0]  i_hit_sa_word,
    input  logic                      i_flush,
    input  logic                      i_ubit_upd_sa_ready,
    output logic [SET_ADDR_WIDTH-1:0] o_ubit_upd_sa_set_addr,
    output logic [SA_WORD_WIDTH-1:0]  o_ubit_upd_sa_data,
    output logic [NUM_WAYS-1:0]       o_ubit_upd_sa_mask,
    output logic                      o_ubit_upd_sa_valid,
    output logic                      o_drop
);

    localparam int                 c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int                 c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(FIFO_DEPTH);

    sa_w_req                  r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]       r_rd_ptr;
    logic [c_ptr_w-1:0]       r_wr_ptr;
    logic [c_cnt_w-1:0]       r_count;

    logic [SA_WORD_WIDTH-1:0] w_hit_data;
    logic [NUM_WAYS-1:0]      w_hit_mask;
    logic                     w_valid;
    logic                     w_full;
    logic                     w_pop;
    logic                     w_push_req;
    logic                     w_push;
    logic                     w_merge;
    sa_w_req                  w_head;

    ubit_next_calc u_hit_calc (
        .i_sa_word (i_hit_sa_word),
        .i_hit_way (i_hit_way),
        .o_data    (w_hit_data),
        .o_mask    (w_hit_mask)
    );

`ifdef UBIT_COALESCE_EN
    logic [c_ptr_w-1:0]       w_merge_idx;
    logic                     w_merge_found;
    logic [SA_WORD_WIDTH-1:0] w_merge_data;
    logic [NUM_WAYS-1:0]      w_merge_chg;

    // Offsets start at 1 so the head, possibly mid-handshake, is never touched;
    // later matches overwrite earlier ones, leaving the youngest.
    always_comb begin
        w_merge_found = 1'b0;
        w_merge_idx   = r_rd_ptr;
        for (int i = 1; i < FIFO_DEPTH; i++) begin
            if ((c_cnt_w'(i) < r_count) &&
                (r_mem[r_rd_ptr + c_ptr_w'(i)].set_addr == i_hit_set_addr)) begin
                w_merge_found = 1'b1;
                w_merge_idx   = r_rd_ptr + c_ptr_w'(i);
            end
        end
    end

    assign w_merge = i_hit_valid & w_merge_found & ~i_flush;

    ubit_next_calc u_merge_calc (
        .i_sa_word (r_mem[w_merge_idx].data),
        .i_hit_way (i_hit_way),
        .o_data    (w_merge_data),
        .o_mask    (w_merge_chg)
    );
`else
    assign w_merge = 1'b0;
`endif

    assign w_valid    = (r_count != '0);
    assign w_full     = (r_count == c_full);
    assign w_pop      = w_valid & i_ubit_upd_sa_ready;
    assign w_push_req = i_hit_valid & (|w_hit_mask) & ~w_merge;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign o_drop     = rstn & ~i_flush & w_push_req & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{set_addr: i_hit_set_addr, data: w_hit_data, mask: w_hit_mask};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
`ifdef UBIT_COALESCE_EN
            if (w_merge) begin
                r_mem[w_merge_idx].data <= w_merge_data;
                r_mem[w_merge_idx].mask <= r_mem[w_merge_idx].mask | w_merge_chg;
            end
`endif
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    // Storage is not reset; outputs are zeroed whenever the queue is empty.
    assign w_head                 = r_mem[r_rd_ptr];
    assign o_ubit_upd_sa_valid    = w_valid;
    assign o_ubit_upd_sa_set_addr = w_valid ? w_head.set_addr : '0;
    assign o_ubit_upd_sa_data     = w_valid ? w_head.data     : '0;
    assign o_ubit_upd_sa_mask     = w_valid ? w_head.mask     : '0;

    a_hit_way_onehot: assert property (@(posedge clk) disable iff (!rstn)
        i_hit_valid |-> $onehot(i_hit_way));

endmodule

`default_nettype wire
